// File: rtl/des_key_sched.sv
// DES key-schedule engine: stores NUM_SLOTS keys in PC-1 form. On start it walks
// one slot's C/D halves with a rotate-and-PC-2 datapath and streams the 16 round
// subkeys, in encrypt order (K1..K16) or decrypt order (K16..K1).
//
// Handshake: key_out_valid is high for the whole RUN state. A subkey transfers on
// a rising edge where key_out_valid && key_out_ready_in. While valid is high and
// ready is low, key_out and key_out_idx hold. key_out_valid never depends
// combinationally on key_out_ready_in.
module des_key_sched #(
    parameter int NUM_SLOTS = 3,
    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              key_wr_in,
    input  logic [SLOT_W-1:0] key_wr_slot_in,
    input  logic [63:0]       key_wr_data_in,
    input  logic              start_in,
    input  logic [SLOT_W-1:0] start_slot_in,
    input  logic              start_decrypt_in,
    output logic              busy_out,
    output logic              err_out,
    output logic [47:0]       key_out,
    output logic [3:0]        key_out_idx,
    output logic              key_out_valid,
    input  logic              key_out_ready_in,
    output logic              done_out
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [SLOT_W:0] SLOT_LIMIT = (SLOT_W + 1)'(NUM_SLOTS);

    state_t      state_q, state_d;
    logic [55:0] slot_q [NUM_SLOTS];
    logic [55:0] cd_q;
    logic        dec_q;
    logic [3:0]  idx_q;
    logic [47:0] key_q;
    logic        done_q, err_q;

    logic        wr_slot_ok, start_slot_ok;
    logic        start_ok, start_err, wr_err;
    logic        xfer, last;
    logic [55:0] key_pc1;
    logic [55:0] sel_cd, cd_first, cd_step, cd_load;
    logic [47:0] key_d;
    logic        two_enc, two_dec;
    logic        unused_parity;

    // Rotation amount for a round: 1 for rounds 1, 2, 9, 16 (idx 0, 1, 8, 15), else 2.
    function automatic logic shift_two(input logic [3:0] r);
        return !(r == 4'd0 || r == 4'd1 || r == 4'd8 || r == 4'd15);
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    // PC-1: FIPS bit n of the key is key_wr_data_in[64-n]. Parity bits are dropped.
    assign key_pc1 = {
        key_wr_data_in[7],  key_wr_data_in[15], key_wr_data_in[23], key_wr_data_in[31],
        key_wr_data_in[39], key_wr_data_in[47], key_wr_data_in[55],
        key_wr_data_in[63], key_wr_data_in[6],  key_wr_data_in[14], key_wr_data_in[22],
        key_wr_data_in[30], key_wr_data_in[38], key_wr_data_in[46],
        key_wr_data_in[54], key_wr_data_in[62], key_wr_data_in[5],  key_wr_data_in[13],
        key_wr_data_in[21], key_wr_data_in[29], key_wr_data_in[37],
        key_wr_data_in[45], key_wr_data_in[53], key_wr_data_in[61], key_wr_data_in[4],
        key_wr_data_in[12], key_wr_data_in[20], key_wr_data_in[28],
        key_wr_data_in[1],  key_wr_data_in[9],  key_wr_data_in[17], key_wr_data_in[25],
        key_wr_data_in[33], key_wr_data_in[41], key_wr_data_in[49],
        key_wr_data_in[57], key_wr_data_in[2],  key_wr_data_in[10], key_wr_data_in[18],
        key_wr_data_in[26], key_wr_data_in[34], key_wr_data_in[42],
        key_wr_data_in[50], key_wr_data_in[58], key_wr_data_in[3],  key_wr_data_in[11],
        key_wr_data_in[19], key_wr_data_in[27], key_wr_data_in[35],
        key_wr_data_in[43], key_wr_data_in[51], key_wr_data_in[59], key_wr_data_in[36],
        key_wr_data_in[44], key_wr_data_in[52], key_wr_data_in[60]
    };

    assign unused_parity = ^{key_wr_data_in[0],  key_wr_data_in[8],  key_wr_data_in[16],
                             key_wr_data_in[24], key_wr_data_in[32], key_wr_data_in[40],
                             key_wr_data_in[48], key_wr_data_in[56]};

    assign wr_slot_ok    = ({1'b0, key_wr_slot_in} < SLOT_LIMIT);
    assign start_slot_ok = ({1'b0, start_slot_in} < SLOT_LIMIT);
    assign wr_err        = key_wr_in && !wr_slot_ok;

    assign xfer = (state_q == RUN) && key_out_ready_in;
    assign last = dec_q ? (idx_q == 4'd0) : (idx_q == 4'd15);

    // Select the stored C/D of the requested start slot.
    always_comb begin
        sel_cd = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (start_slot_in == SLOT_W'(i)) sel_cd = slot_q[i];
        end
    end

    // Next C/D: first round on start, otherwise one step forward or backward.
    always_comb begin
        two_enc  = shift_two(idx_q + 4'd1);
        two_dec  = shift_two(idx_q);
        cd_first = start_decrypt_in ? sel_cd
                                    : {rotl(sel_cd[55:28], 1'b0), rotl(sel_cd[27:0], 1'b0)};
        cd_step  = dec_q ? {rotr(cd_q[55:28], two_dec), rotr(cd_q[27:0], two_dec)}
                         : {rotl(cd_q[55:28], two_enc), rotl(cd_q[27:0], two_enc)};
        cd_load  = start_ok ? cd_first : cd_step;
    end

    // PC-2 of the C/D value about to be loaded: cd bit n (FIPS) is cd_load[56-n].
    assign key_d = {
        cd_load[42], cd_load[39], cd_load[45], cd_load[32], cd_load[55], cd_load[51],
        cd_load[53], cd_load[28], cd_load[41], cd_load[50], cd_load[35], cd_load[46],
        cd_load[33], cd_load[37], cd_load[44], cd_load[52], cd_load[30], cd_load[48],
        cd_load[40], cd_load[49], cd_load[29], cd_load[36], cd_load[43], cd_load[54],
        cd_load[15], cd_load[4],  cd_load[25], cd_load[19], cd_load[9],  cd_load[1],
        cd_load[26], cd_load[16], cd_load[5],  cd_load[11], cd_load[23], cd_load[8],
        cd_load[12], cd_load[7],  cd_load[17], cd_load[0],  cd_load[22], cd_load[3],
        cd_load[10], cd_load[14], cd_load[6],  cd_load[20], cd_load[27], cd_load[24]
    };

    // FSM state register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // FSM next state and request classification.
    always_comb begin
        state_d   = state_q;
        start_ok  = 1'b0;
        start_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    if (start_slot_ok) begin
                        start_ok = 1'b1;
                        state_d  = RUN;
                    end else begin
                        start_err = 1'b1;
                    end
                end
            end
            RUN: begin
                start_err = start_in;
                if (xfer && last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Key storage; writes are independent of the running schedule.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= '0;
        end else if (key_wr_in && wr_slot_ok) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (key_wr_slot_in == SLOT_W'(i)) slot_q[i] <= key_pc1;
            end
        end
    end

    // Schedule datapath: private C/D copy, round index and registered subkey.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cd_q   <= '0;
            dec_q  <= 1'b0;
            idx_q  <= '0;
            key_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= xfer && last;
            err_q  <= start_err || wr_err;
            if (start_ok) begin
                cd_q  <= cd_load;
                key_q <= key_d;
                dec_q <= start_decrypt_in;
                idx_q <= start_decrypt_in ? 4'd15 : 4'd0;
            end else if (xfer && !last) begin
                cd_q  <= cd_load;
                key_q <= key_d;
                idx_q <= dec_q ? idx_q - 4'd1 : idx_q + 4'd1;
            end
        end
    end

    assign busy_out      = (state_q == RUN);
    assign key_out_valid = (state_q == RUN);
    assign key_out       = key_q;
    assign key_out_idx   = idx_q;
    assign done_out      = done_q;
    assign err_out       = err_q;

endmodule

// File: doc/des_key_sched.md
Name: des_key_sched

Overview:
- Sequential DES key-schedule engine holding NUM_SLOTS raw 64-bit keys (e.g. K1/K2/K3 for 3DES).
- On start, walks one slot's schedule and streams all 16 48-bit round subkeys over a valid/ready interface, one per handshake.
- Encrypt order is K1..K16; decrypt order is K16..K1.
- Sits between key-load control and the round datapath. Replaces per-index combinational subkey selection with a stateful rotate-and-PC-2 engine.

Parameters:
- NUM_SLOTS, 3: number of stored keys; legal range 1..8.
- SLOT_W, derived as max(1, $clog2(NUM_SLOTS)): width of slot select ports. Localparam, not overridable.

Ports:
- clk_in  input  1  clock; all logic on rising edge.
- rst_n_in  input  1  asynchronous active-low reset.
- key_wr_in  input  1  write strobe for key storage.
- key_wr_slot_in  input  SLOT_W  slot to write.
- key_wr_data_in  input  64  raw DES key, FIPS bit 1 = bit 63. Parity bits are ignored.
- start_in  input  1  start-schedule request, accepted only in IDLE.
- start_slot_in  input  SLOT_W  slot to schedule.
- start_decrypt_in  input  1  0 = encrypt order, 1 = decrypt order.
- busy_out  output  1  high while in RUN.
- err_out  output  1  one-cycle pulse on a rejected request.
- key_out  output  48  round subkey, FIPS bit 1 = bit 47.
- key_out_idx  output  4  round index of key_out, 0..15 (0 = K1).
- key_out_valid  output  1  subkey valid.
- key_out_ready_in  input  1  consumer accepts subkey.
- done_out  output  1  one-cycle pulse after the 16th handshake.

Behaviour:
- Reset (asynchronous, active-low): all outputs 0, FSM returns to IDLE, every slot cleared to 0. Reset mid-RUN aborts the schedule immediately and emits no done_out.
- Key storage: key_wr_in stores PC-1(key_wr_data_in) (56 bits, C||D) into the slot on the next edge. Writes are allowed in any state.
  - A write to slot >= NUM_SLOTS is dropped and pulses err_out.
  - A write to the slot in use during RUN does not disturb the running schedule, because RUN works on a private C/D copy.
- FSM states IDLE and RUN.
- IDLE -> RUN when start_in=1 and start_slot_in < NUM_SLOTS.
  - Loads the C/D copy from the slot, latches the mode and sets the round counter.
  - start_in with slot >= NUM_SLOTS: stays IDLE, err_out pulses.
  - start_in while in RUN: ignored, err_out pulses.
- Same-cycle write and start to the same slot: start uses the pre-write contents.
- Latency: start accepted at edge T; key_out_valid=1 with the first subkey from edge T+1.
- Encrypt: emits PC-2 of C/D after cumulative left rotations; shifts per round are 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. key_out_idx counts 0..15.
- Decrypt: first emits PC-2(C0||D0) = K16, then right-rotates by the reversed shift table. key_out_idx counts 15..0.
- Handshake: transfer occurs on an edge with key_out_valid && key_out_ready_in.
  - While valid and not ready, key_out and key_out_idx hold stable.
  - With ready held high, one subkey is transferred per cycle, 16 consecutive cycles.
- After the 16th transfer: next cycle key_out_valid=0, busy_out=0, done_out=1 for one cycle, FSM in IDLE.
  - A new start is accepted in that same cycle, so the minimum start-to-start interval is 17 cycles.
- key_out retains its last value when not valid.
- err_out and done_out are never high for more than one cycle per event.

Test Plan:
- Encrypt, ready held high: write 0x133457799BBCDFF1 to slot 0, start (slot 0, encrypt).
  - K1 = 0x1B02EFFC7072 idx 0, K2 = 0x79AED9DBC9E5 idx 1, K16 = 0xCB3D8B0E17F5 idx 15.
  - 16 consecutive valid cycles, then done_out pulse.
- Decrypt, same key: first subkey 0xCB3D8B0E17F5 idx 15, second idx 14; last 0x1B02EFFC7072 idx 0.
  - Full sequence equals the encrypt sequence reversed.
- Backpressure: randomised key_out_ready_in.
  - key_out and key_out_idx stable during stalls.
  - No subkey lost or duplicated; exactly 16 transfers.
- Slots and errors: with NUM_SLOTS=3, write distinct keys to slots 0..2, schedule each and compare against a model.
  - start_slot_in=3 -> err_out pulse, busy_out stays 0.
  - start during RUN -> err_out pulse, no disturbance.
- Write during RUN: rewrite the active slot mid-schedule -> current stream unchanged; the next start uses the new key.
  - Same-cycle write and start to slot 1 -> old key scheduled.
- Reset: assert rst_n_in after the 5th transfer -> outputs 0 immediately, no done_out.
  - After release, a start on slot 0 yields 0 subkeys' worth of data, i.e. K1 = PC-2(0) = 0x000000000000, because the slot was cleared.
